frac_logic_ccff_loader: RTL and testbench

Sequencer that programs the configuration-chain flip-flops of one frac_logic tile: LUT4/arith content, mode bits and output-mux select.
- Accepts configuration words over a valid/ready stream.
- Serialises them LSB-first onto ccff_head and drives config_enable for exactly CHAIN_LEN shift cycles.
- Reports completion. Optionally re-circulates the chain to verify it against a shadow copy.
- Sits between the PMU bitstream source and the tile's ccff_head/ccff_tail pins.

---
 rtl/frac_logic_cfg_pkg.sv | 19 +
 rtl/frac_logic_ccff_serializer.sv | 47 ++++
 rtl/frac_logic_ccff_loader.sv | 159 +++++++++++++++
 tb/tb_frac_logic_ccff_loader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/frac_logic_cfg_pkg.sv
// Shared types and constants for the frac_logic configuration-chain loader.
package frac_logic_cfg_pkg;

    localparam int unsigned FRAC_LOGIC_CHAIN_LEN = 20;
    localparam int unsigned FRAC_LOGIC_WORD_W    = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StVerify,
        StDone
    } ccff_state_e;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/frac_logic_ccff_serializer.sv
// Word shift register, per-word beat counter and the ccff_head output register.
module frac_logic_ccff_serializer
    import frac_logic_cfg_pkg::*;
#(
    parameter int unsigned WORD_W = FRAC_LOGIC_WORD_W,
    parameter int unsigned BEAT_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic [BEAT_W-1:0] i_beat_init,
    input  logic              i_shift,
    input  logic              i_rot,
    input  logic              i_tail,
    output logic              o_head,
    output logic              o_beat_last
);

    logic [WORD_W-1:0] r_sreg;
    logic [BEAT_W-1:0] r_beat;
    logic              r_head;

    assign o_beat_last = (r_beat == BEAT_W'(1));
    assign o_head      = i_rot ? i_tail : r_head;

    // Head is preloaded with bit 0 on accept, so it is valid on the first shift cycle;
    // it is not advanced past the last bit of a beat, so it holds across stalls.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sreg <= '0;
            r_beat <= '0;
            r_head <= 1'b0;
        end else if (i_load) begin
            r_sreg <= {1'b0, i_data[WORD_W-1:1]};
            r_head <= i_data[0];
            r_beat <= i_beat_init;
        end else if (i_shift) begin
            r_beat <= r_beat - BEAT_W'(1);
            if (!o_beat_last) begin
                r_head <= r_sreg[0];
                r_sreg <= {1'b0, r_sreg[WORD_W-1:1]};
            end
        end
    end

endmodule

// File: rtl/frac_logic_ccff_loader.sv
// Programs one frac_logic tile configuration chain from a word stream.
// Optional chain read-back verify: FRAC_LOGIC_CCFF_VERIFY_EN.
module frac_logic_ccff_loader
    import frac_logic_cfg_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = FRAC_LOGIC_CHAIN_LEN,
    parameter int unsigned WORD_W    = FRAC_LOGIC_WORD_W
) (
    input  logic              i_prog_clk,
    input  logic              i_preset,
    input  logic              i_start,
    input  logic              i_word_valid,
    input  logic [WORD_W-1:0] i_word_data,
    output logic              o_word_ready,
    output logic              o_ccff_head,
    input  logic              i_ccff_tail,
    output logic              o_config_enable,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int unsigned BIT_W  = $clog2(CHAIN_LEN + 1);
    localparam int unsigned BEAT_W = $clog2(WORD_W + 1);

    ccff_state_e      r_state;
    logic             r_word_ready;
    logic             r_config_enable;
    logic             r_busy;
    logic             r_done;
    logic [BIT_W-1:0] r_bit_cnt;

    logic              w_accept;
    logic              w_shift;
    logic              w_rot;
    logic              w_last_bit;
    logic              w_beat_last;
    logic              w_head;
    logic [BEAT_W-1:0] w_beat_init;

    assign w_accept    = r_word_ready && i_word_valid;
    assign w_shift     = (r_state == StShift);
    assign w_rot       = (r_state == StVerify);
    assign w_last_bit  = (r_bit_cnt == BIT_W'(CHAIN_LEN - 1));
    // Final word is truncated to the bits the chain still needs.
    assign w_beat_init = BEAT_W'(min_u(WORD_W, CHAIN_LEN - 32'(r_bit_cnt)));

    frac_logic_ccff_serializer #(
        .WORD_W (WORD_W),
        .BEAT_W (BEAT_W)
    ) u_serializer (
        .i_clk       (i_prog_clk),
        .i_rst       (i_preset),
        .i_load      (w_accept),
        .i_data      (i_word_data),
        .i_beat_init (w_beat_init),
        .i_shift     (w_shift),
        .i_rot       (w_rot),
        .i_tail      (i_ccff_tail),
        .o_head      (w_head),
        .o_beat_last (w_beat_last)
    );

    always_ff @(posedge i_prog_clk or posedge i_preset) begin
        if (i_preset) begin
            r_state         <= StIdle;
            r_word_ready    <= 1'b0;
            r_config_enable <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_bit_cnt       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state      <= StLoad;
                        r_word_ready <= 1'b1;
                        r_busy       <= 1'b1;
                        r_bit_cnt    <= '0;
                    end
                end
                StLoad: begin
                    if (i_word_valid) begin
                        r_state         <= StShift;
                        r_word_ready    <= 1'b0;
                        r_config_enable <= 1'b1;
                    end
                end
                StShift: begin
                    r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    if (w_beat_last) begin
                        if (w_last_bit) begin
`ifdef FRAC_LOGIC_CCFF_VERIFY_EN
                            r_state   <= StVerify;
                            r_bit_cnt <= '0;
`else
                            r_state         <= StDone;
                            r_done          <= 1'b1;
                            r_config_enable <= 1'b0;
`endif
                        end else begin
                            r_state         <= StLoad;
                            r_word_ready    <= 1'b1;
                            r_config_enable <= 1'b0;
                        end
                    end
                end
                StVerify: begin
                    r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    if (w_last_bit) begin
                        r_state         <= StDone;
                        r_done          <= 1'b1;
                        r_config_enable <= 1'b0;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef FRAC_LOGIC_CCFF_VERIFY_EN
    logic [CHAIN_LEN-1:0] r_shadow;
    logic                 r_err;

    // Shadow mirrors the chain; rotating it during verify keeps the oldest bit at the MSB.
    always_ff @(posedge i_prog_clk or posedge i_preset) begin
        if (i_preset) begin
            r_shadow <= '0;
            r_err    <= 1'b0;
        end else if ((r_state == StIdle) && i_start) begin
            r_shadow <= '0;
            r_err    <= 1'b0;
        end else if (w_shift) begin
            r_shadow <= {r_shadow[CHAIN_LEN-2:0], w_head};
        end else if (w_rot) begin
            r_shadow <= {r_shadow[CHAIN_LEN-2:0], r_shadow[CHAIN_LEN-1]};
            if (i_ccff_tail != r_shadow[CHAIN_LEN-1]) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_word_ready    = r_word_ready;
    assign o_ccff_head     = w_head;
    assign o_config_enable = r_config_enable;
    assign o_busy          = r_busy;
    assign o_done          = r_done;

endmodule

// File: tb/tb_frac_logic_ccff_loader.sv
// Randomised self-checking bench for frac_logic_ccff_loader against a bit-list chain model.
module tb_frac_logic_ccff_loader;

    localparam int unsigned CL = 20;
    localparam int unsigned WW = 8;
`ifdef FRAC_LOGIC_CCFF_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif
    localparam int ACCEPTS = (CL + WW - 1) / WW;

    logic          clk;
    logic          rst;
    logic          start;
    logic          word_valid;
    logic [WW-1:0] word_data;
    logic          word_ready;
    logic          ccff_head;
    logic          ccff_tail;
    logic          config_enable;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    // Tile chain model and observation log
    logic [CL-1:0] chain = '0;
    logic          hq[$];
    int            en_total = 0;
    int            done_total = 0;
    int            en_base = 0;
    bit            fault_en = 1'b0;

    frac_logic_ccff_loader #(
        .CHAIN_LEN (CL),
        .WORD_W    (WW)
    ) dut (
        .i_prog_clk      (clk),
        .i_preset        (rst),
        .i_start         (start),
        .i_word_valid    (word_valid),
        .i_word_data     (word_data),
        .o_word_ready    (word_ready),
        .o_ccff_head     (ccff_head),
        .i_ccff_tail     (ccff_tail),
        .o_config_enable (config_enable),
        .o_busy          (busy),
        .o_done          (done),
        .o_err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fault injection: the 8th bit read back during verify is stuck at 1.
    assign ccff_tail = (fault_en && (en_total - en_base == CL + 7)) ? 1'b1 : chain[CL-1];

    always @(posedge clk) begin
        if (config_enable) begin
            hq.push_back(ccff_head);
            chain    <= {chain[CL-2:0], ccff_head};
            en_total <= en_total + 1;
        end
        if (done) done_total <= done_total + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                            input logic [WW-1:0] w2, input int stall_n, input bit noise,
                            input bit fault, input bit chk_chain);
        logic [WW-1:0] w[3];
        logic [CL-1:0] exp_bits;
        logic [CL-1:0] exp_chain;
        logic [CL-1:0] got;
        int idx, stall, cyc, en0, hq0, d0;
        bit fin;
        w[0] = w0; w[1] = w1; w[2] = w2;
        for (int i = 0; i < CL; i++) begin
            exp_bits[i]          = w[i / WW][i % WW];
            exp_chain[CL-1-i]    = exp_bits[i];
        end
        @(negedge clk);
        en0 = en_total; hq0 = hq.size(); d0 = done_total;
        en_base = en0; fault_en = fault;
        start = 1'b1;
        idx = 0; stall = 0; cyc = 0; fin = 1'b0;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            word_valid = 1'b0;
            if (done) begin
                fin = 1'b1;
            end else if (word_ready) begin
                if (idx == 1 && stall < stall_n) begin
                    stall++;
                    check("stall_enable", config_enable, 1'b0);
                    check("stall_head_held", ccff_head, exp_bits[WW-1]);
                end else if (idx < 3) begin
                    word_valid = 1'b1;
                    word_data  = w[idx];
                    idx++;
                end
            end else if (config_enable && noise) begin
                word_valid = 1'b1;
                word_data  = WW'($urandom);
                start      = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
        word_valid = 1'b0;
        check("done_seen", fin, 1'b1);
        check("latency", cyc, ACCEPTS + CL + 1 + stall_n + (VER ? CL : 0));
        repeat (3) @(negedge clk);
        check("done_pulses", done_total - d0, 1);
        check("enable_cycles", en_total - en0, VER ? 2 * CL : CL);
        for (int i = 0; i < CL; i++) got[i] = (hq0 + i < hq.size()) ? hq[hq0 + i] : 1'bx;
        check("head_sequence", got, exp_bits);
        if (chk_chain) check("chain_content", chain, exp_chain);
        check("busy_after", busy, 1'b0);
        check("err_after", err, (VER && fault) ? !exp_bits[7] : 1'b0);
        fault_en = 1'b0;
    endtask

    initial begin
        logic [WW-1:0] a, b, c;
        int en0, guard;
        rst = 1'b1; start = 1'b0; word_valid = 1'b0; word_data = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {word_ready, ccff_head, config_enable, busy, done, err}, 6'b0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", {word_ready, config_enable, busy, done, err}, 5'b0);

        // Word stream present before start must be ignored in IDLE
        word_valid = 1'b1; word_data = 8'hFF;
        @(negedge clk);
        check("idle_ignores_valid", {word_ready, busy, config_enable}, 3'b0);
        word_valid = 1'b0;

        run_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0, 1'b0, 1'b1);
        run_load(8'hA5, 8'h3C, 8'h0F, 5, 1'b0, 1'b0, 1'b1);
        run_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b1, 1'b0, 1'b1);

        for (int n = 0; n < 4; n++) begin
            a = WW'($urandom); b = WW'($urandom); c = WW'($urandom);
            run_load(a, b, c, $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        end

        // Reset while the ninth bit is being shifted
        @(negedge clk);
        en0 = en_total; start = 1'b1; guard = 0;
        while (en_total - en0 < 9 && guard < 100) begin
            @(negedge clk);
            guard++;
            start = 1'b0;
            word_valid = word_ready;
            word_data  = WW'($urandom);
        end
        check("reached_bit9", en_total - en0, 9);
        word_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midshift_reset", {config_enable, busy, word_ready, done}, 4'b0);
        rst = 1'b0;
        a = WW'($urandom); b = WW'($urandom); c = WW'($urandom);
        run_load(a, b, c, 0, 1'b0, 1'b0, 1'b1);

`ifdef FRAC_LOGIC_CCFF_VERIFY_EN
        a = WW'($urandom) & 8'h7F;
        run_load(a, WW'($urandom), WW'($urandom), 0, 1'b0, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check("err_sticky", err, 1'b1);
        run_load(WW'($urandom), WW'($urandom), WW'($urandom), 0, 1'b0, 1'b0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
